pcie_mem_req_segmenter: RTL and testbench
=========================================

Name: pcie_mem_req_segmenter

Overview:
- Accepts one host-level memory read or write request (address, byte length, mode).
- Splits the request into a sequence of PCIe 4-DW memory request TLP headers:
  - write segments are limited to MAX_PAYLOAD_SIZE;
  - read segments are limited to MAX_READ_REQ_SIZE;
  - no segment crosses a 4 KB boundary.
- Sits between the DMA command queue and the TLP transmit mux.
- Emits one header per cycle under valid/ready, plus segment byte count and offset for the data mover.

Parameters:
- MAX_PAYLOAD_SIZE, 128, max write segment in bytes (power of 2, 4..4096)
- MAX_READ_REQ_SIZE, 512, max read segment in bytes (power of 2, 4..4096)
- LEN_WIDTH, 13, request byte-length width (legal lengths 1..4096)
- TAG_WIDTH, 8, tag counter width (≤10)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_is_read_i  in  1  1 = MemRd, 0 = MemWr
- req_addr_i  in  64  byte start address
- req_len_i  in  LEN_WIDTH  byte length
- req_id_i  in  16  requester ID (BDF)
- req_tag_i  in  TAG_WIDTH  tag of first segment
- hdr_valid_o  out  1  header valid
- hdr_ready_i  in  1  downstream ready
- hdr_o  out  128  TLP memory request header, layout below
- seg_bytes_o  out  13  byte count of current segment
- seg_offset_o  out  LEN_WIDTH  byte offset of segment within request
- seg_last_o  out  1  current segment is final
- done_o  out  1  one-cycle pulse on final header handshake
- err_o  out  1  one-cycle pulse: illegal length request dropped

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset state:
  - state = IDLE;
  - req_ready_o = 1;
  - hdr_valid_o, done_o, err_o = 0;
  - hdr_o, seg_* = 0.
- States:
  - IDLE: req_ready_o = 1. On handshake, latch the request.
    - If req_len_i == 0 or req_len_i > 4096: pulse err_o the next cycle and stay in IDLE.
    - Otherwise go to EMIT.
  - EMIT: req_ready_o = 0 and hdr_valid_o = 1.
    - Outputs are registered and stable while hdr_ready_i = 0.
    - On handshake with seg_last_o = 0: the next segment's header is presented the following cycle (throughput 1 header/cycle).
    - On handshake with seg_last_o = 1: pulse done_o and return to IDLE; req_ready_o = 1 in that same next cycle.
- Latency: request handshake at cycle N → first hdr_valid_o at N+1.
- Segment size: M = MAX_READ_REQ_SIZE if read, else MAX_PAYLOAD_SIZE. seg_bytes = min(remaining, M − (cur_addr mod M)).
  - M divides 4096, so no segment crosses a 4 KB boundary.
- Per-segment update after each handshake:
  - cur_addr += seg_bytes;
  - remaining −= seg_bytes;
  - offset += seg_bytes;
  - tag += 1 modulo 2^TAG_WIDTH (wraps silently).
- Length in DW: ceil((cur_addr[1:0] + seg_bytes) / 4). The 10-bit field encodes 1024 DW as 0.
- Byte enables:
  - first_be = 4'b1111 << cur_addr[1:0], masked by the end byte if the segment fits in one DW.
  - last_be = 0 if length == 1; otherwise enables bytes 0..((cur_addr + seg_bytes − 1) mod 4).
- Fixed header fields:
  - fmt = 3'b011 (write) or 3'b001 (read); type = 5'b00000;
  - tc, attr, th, ln, td, ep, at = 0.
- hdr_o layout, LSB-first:
  - [4:0] type; [7:5] fmt; [8] th; [9] ln; [10] attr[2]; [11] tag[8]; [14:12] tc; [15] tag[9];
  - [17:16] length[9:8]; [19:18] at; [21:20] attr[1:0]; [22] ep; [23] td; [31:24] length[7:0];
  - [39:32] rid[15:8]; [47:40] rid[7:0]; [55:48] tag[7:0]; [59:56] first_be; [63:60] last_be;
  - [95:64] {addr[39:32], addr[47:40], addr[55:48], addr[63:56]};
  - [119:96] {addr[15:8], addr[23:16], addr[31:24]}; [121:120] 0; [127:122] addr[7:2].
  - Tag bits above TAG_WIDTH are 0.
- Reset mid-EMIT: abandon the request. The next cycle shows reset values; no done_o.
- err_o and done_o never assert together.

Test Plan:
- Write, len 256, addr 0x1000, tag 0x10 → 2 headers:
  - length 32 DW, addr 0x1000 and 0x1080, tags 0x10 and 0x11;
  - offsets 0 and 128, BE 1111/1111;
  - done_o on the second handshake.
- Write, len 10, addr 0x7E:
  - seg 1: 2 B, len 1, first_be 1100, last_be 0000;
  - seg 2: 8 B at 0x80, len 2, BE 1111/1111, seg_last 1.
- Read, len 1024, addr 0x1F00 → segments 256 B @0x1F00 (64 DW), 512 B @0x2000 (128 DW), 256 B @0x2200; fmt 001.
- Backpressure: hold hdr_ready_i = 0 for 5 cycles mid-sequence → hdr_o, seg_* stable; no segment skipped or duplicated.
- Tag wrap: tag 0xFF, 3 segments → tags 0xFF, 0x00, 0x01.
- req_len_i = 0, then 4097 → err_o pulse each, no hdr_valid_o. Separately, rst asserted during EMIT → outputs return to reset values the next cycle; a fresh request is accepted afterwards.

Source files
------------

// File: rtl/pcie_mem_req_segmenter.sv
// Splits one host memory read/write request into a stream of 4-DW PCIe
// memory request TLP headers, one per cycle under valid/ready. Segments are
// capped at MPS (writes) or MRRS (reads) and never cross a 4 KB boundary.
module pcie_mem_req_segmenter #(
    parameter int unsigned MAX_PAYLOAD_SIZE  = 128,
    parameter int unsigned MAX_READ_REQ_SIZE = 512,
    parameter int unsigned LEN_WIDTH         = 13,
    parameter int unsigned TAG_WIDTH         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_is_read_i,
    input  logic [63:0]          req_addr_i,
    input  logic [LEN_WIDTH-1:0] req_len_i,
    input  logic [15:0]          req_id_i,
    input  logic [TAG_WIDTH-1:0] req_tag_i,
    output logic                 hdr_valid_o,
    input  logic                 hdr_ready_i,
    output logic [127:0]         hdr_o,
    output logic [12:0]          seg_bytes_o,
    output logic [LEN_WIDTH-1:0] seg_offset_o,
    output logic                 seg_last_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e               state_q, state_d;
    logic [63:0]          addr_q, addr_d;
    logic [12:0]          rem_q, rem_d;
    logic [LEN_WIDTH-1:0] offset_q, offset_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 is_read_q, is_read_d;
    logic [15:0]          rid_q, rid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [12:0]  seg_max;
    logic [12:0]  room;
    logic [12:0]  seg_bytes;
    logic         seg_last;
    logic [11:0]  dw_cnt;
    logic [1:0]   end_idx;
    logic [3:0]   end_mask;
    logic [3:0]   first_be;
    logic [3:0]   last_be;
    logic [9:0]   tag10;
    logic [127:0] hdr;
    logic [31:0]  req_len_32;
    logic         len_bad;

    // Current segment geometry and header, derived from the held request state
    always_comb begin
        seg_max   = is_read_q ? 13'(MAX_READ_REQ_SIZE) : 13'(MAX_PAYLOAD_SIZE);
        // Bytes left before the next M-aligned address; M divides 4096
        room      = seg_max - (addr_q[12:0] & (seg_max - 13'd1));
        seg_bytes = (rem_q < room) ? rem_q : room;
        seg_last  = (rem_q == seg_bytes);
        dw_cnt    = 12'((14'(addr_q[1:0]) + 14'(seg_bytes) + 14'd3) >> 2);
        end_idx   = addr_q[1:0] + seg_bytes[1:0] - 2'd1;
        end_mask  = 4'b1111 >> (2'd3 - end_idx);
        first_be  = 4'b1111 << addr_q[1:0];
        if (dw_cnt == 12'd1) begin
            first_be = first_be & end_mask;
            last_be  = 4'b0000;
        end else begin
            last_be  = end_mask;
        end
        tag10 = '0;
        tag10[TAG_WIDTH-1:0] = tag_q;

        hdr          = '0;
        hdr[7:5]     = is_read_q ? 3'b001 : 3'b011;
        hdr[11]      = tag10[8];
        hdr[15]      = tag10[9];
        // 1024 DW wraps to 0 in the 10-bit length field
        hdr[17:16]   = dw_cnt[9:8];
        hdr[31:24]   = dw_cnt[7:0];
        hdr[39:32]   = rid_q[15:8];
        hdr[47:40]   = rid_q[7:0];
        hdr[55:48]   = tag10[7:0];
        hdr[59:56]   = first_be;
        hdr[63:60]   = last_be;
        hdr[95:64]   = {addr_q[39:32], addr_q[47:40], addr_q[55:48], addr_q[63:56]};
        hdr[119:96]  = {addr_q[15:8], addr_q[23:16], addr_q[31:24]};
        hdr[127:122] = addr_q[7:2];
    end

    // Request legality check on the incoming length
    always_comb begin
        req_len_32 = 32'(req_len_i);
        len_bad    = (req_len_32 == 32'd0) || (req_len_32 > 32'd4096);
    end

    // Next-state: accept request in idle, advance one segment per header handshake
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        offset_d  = offset_q;
        tag_d     = tag_q;
        is_read_d = is_read_q;
        rid_d     = rid_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d    = req_addr_i;
                        rem_d     = req_len_32[12:0];
                        offset_d  = '0;
                        tag_d     = req_tag_i;
                        is_read_d = req_is_read_i;
                        rid_d     = req_id_i;
                        state_d   = StEmit;
                    end
                end
            end
            StEmit: begin
                if (hdr_ready_i) begin
                    addr_d   = addr_q + 64'(seg_bytes);
                    rem_d    = rem_q - seg_bytes;
                    offset_d = offset_q + LEN_WIDTH'(seg_bytes);
                    tag_d    = tag_q + 1'b1;
                    if (seg_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rem_q     <= '0;
            offset_q  <= '0;
            tag_q     <= '0;
            is_read_q <= 1'b0;
            rid_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            offset_q  <= offset_d;
            tag_q     <= tag_d;
            is_read_q <= is_read_d;
            rid_q     <= rid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Outputs come from held state only; segment fields read zero while idle
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        hdr_valid_o  = (state_q == StEmit);
        hdr_o        = hdr_valid_o ? hdr : '0;
        seg_bytes_o  = hdr_valid_o ? seg_bytes : '0;
        seg_offset_o = hdr_valid_o ? offset_q : '0;
        seg_last_o   = hdr_valid_o & seg_last;
        done_o       = done_q;
        err_o        = err_q;
    end

endmodule

// File: tb/tb_pcie_mem_req_segmenter.sv
// Directed, table-driven bench for the memory request segmenter.
module tb_pcie_mem_req_segmenter;

    localparam logic [15:0] RID = 16'hABCD;

    logic         clk;
    logic         rst;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_is_read_i;
    logic [63:0]  req_addr_i;
    logic [12:0]  req_len_i;
    logic [15:0]  req_id_i;
    logic [7:0]   req_tag_i;
    logic         hdr_valid_o;
    logic         hdr_ready_i;
    logic [127:0] hdr_o;
    logic [12:0]  seg_bytes_o;
    logic [12:0]  seg_offset_o;
    logic         seg_last_o;
    logic         done_o;
    logic         err_o;

    pcie_mem_req_segmenter #(
        .MAX_PAYLOAD_SIZE (128),
        .MAX_READ_REQ_SIZE(512),
        .LEN_WIDTH        (13),
        .TAG_WIDTH        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_is_read_i(req_is_read_i),
        .req_addr_i   (req_addr_i),
        .req_len_i    (req_len_i),
        .req_id_i     (req_id_i),
        .req_tag_i    (req_tag_i),
        .hdr_valid_o  (hdr_valid_o),
        .hdr_ready_i  (hdr_ready_i),
        .hdr_o        (hdr_o),
        .seg_bytes_o  (seg_bytes_o),
        .seg_offset_o (seg_offset_o),
        .seg_last_o   (seg_last_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          bytes;
        int          offset;
        int          dw;
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        logic [7:0]  tag;
        bit          last;
    } seg_t;

    typedef struct {
        bit          rd;
        logic [63:0] addr;
        int          len;
        logic [7:0]  tag;
        int          first;
        int          nseg;
        int          bp_seg;
    } req_t;

    seg_t segs[11];
    req_t reqs[5];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] exp_hdr(input bit rd, input logic [63:0] a, input int dw,
                                             input logic [3:0] fbe, input logic [3:0] lbe,
                                             input logic [7:0] tag);
        logic [127:0] h;
        logic [9:0]   len10;
        h     = '0;
        len10 = 10'(dw);
        h[7:5]     = rd ? 3'b001 : 3'b011;
        h[17:16]   = len10[9:8];
        h[31:24]   = len10[7:0];
        h[39:32]   = RID[15:8];
        h[47:40]   = RID[7:0];
        h[55:48]   = tag;
        h[59:56]   = fbe;
        h[63:60]   = lbe;
        h[71:64]   = a[63:56];
        h[79:72]   = a[55:48];
        h[87:80]   = a[47:40];
        h[95:88]   = a[39:32];
        h[103:96]  = a[31:24];
        h[111:104] = a[23:16];
        h[119:112] = a[15:8];
        h[127:122] = a[7:2];
        return h;
    endfunction

    task automatic check_seg(input bit rd, input seg_t e);
        chk("hdr_valid", 128'(hdr_valid_o), 128'(1));
        chk("req_ready_busy", 128'(req_ready_o), 128'(0));
        chk("hdr", hdr_o, exp_hdr(rd, e.addr, e.dw, e.fbe, e.lbe, e.tag));
        chk("seg_bytes", 128'(seg_bytes_o), 128'(e.bytes));
        chk("seg_offset", 128'(seg_offset_o), 128'(e.offset));
        chk("seg_last", 128'(seg_last_o), 128'(e.last));
        chk("done_mid", 128'(done_o), 128'(0));
    endtask

    task automatic drive_req(input bit rd, input logic [63:0] a, input int len,
                             input logic [7:0] tag);
        req_valid_i   = 1'b1;
        req_is_read_i = rd;
        req_addr_i    = a;
        req_len_i     = 13'(len);
        req_id_i      = RID;
        req_tag_i     = tag;
    endtask

    task automatic run_req(input req_t r);
        @(negedge clk);
        chk("req_ready_idle", 128'(req_ready_o), 128'(1));
        chk("done_idle", 128'(done_o), 128'(0));
        drive_req(r.rd, r.addr, r.len, r.tag);
        @(negedge clk);
        req_valid_i = 1'b0;
        for (int s = 0; s < r.nseg; s++) begin
            if (s == r.bp_seg) begin
                for (int c = 0; c < 5; c++) begin
                    hdr_ready_i = 1'b0;
                    check_seg(r.rd, segs[r.first + s]);
                    @(negedge clk);
                end
            end
            check_seg(r.rd, segs[r.first + s]);
            hdr_ready_i = 1'b1;
            @(negedge clk);
            hdr_ready_i = 1'b0;
        end
        chk("done_pulse", 128'(done_o), 128'(1));
        chk("hdr_valid_after", 128'(hdr_valid_o), 128'(0));
        chk("req_ready_after", 128'(req_ready_o), 128'(1));
        chk("err_quiet", 128'(err_o), 128'(0));
    endtask

    task automatic err_case(input int len);
        @(negedge clk);
        drive_req(1'b0, 64'h1000, len, 8'h00);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("err_pulse", 128'(err_o), 128'(1));
        chk("err_no_hdr", 128'(hdr_valid_o), 128'(0));
        chk("err_no_done", 128'(done_o), 128'(0));
        @(negedge clk);
        chk("err_clear", 128'(err_o), 128'(0));
        chk("err_no_hdr2", 128'(hdr_valid_o), 128'(0));
    endtask

    initial begin
        rst           = 1'b1;
        req_valid_i   = 1'b0;
        req_is_read_i = 1'b0;
        req_addr_i    = '0;
        req_len_i     = '0;
        req_id_i      = '0;
        req_tag_i     = '0;
        hdr_ready_i   = 1'b0;

        // Write 256 B @0x1000
        segs[0]  = '{64'h1000, 128, 0, 32, 4'hF, 4'hF, 8'h10, 1'b0};
        segs[1]  = '{64'h1080, 128, 128, 32, 4'hF, 4'hF, 8'h11, 1'b1};
        // Write 10 B @0x7E
        segs[2]  = '{64'h7E, 2, 0, 1, 4'b1100, 4'b0000, 8'h20, 1'b0};
        segs[3]  = '{64'h80, 8, 2, 2, 4'hF, 4'hF, 8'h21, 1'b1};
        // Read 1024 B @0x1F00
        segs[4]  = '{64'h1F00, 256, 0, 64, 4'hF, 4'hF, 8'h30, 1'b0};
        segs[5]  = '{64'h2000, 512, 256, 128, 4'hF, 4'hF, 8'h31, 1'b0};
        segs[6]  = '{64'h2200, 256, 768, 64, 4'hF, 4'hF, 8'h32, 1'b1};
        // Write 384 B, tag wrap, high address bits
        segs[7]  = '{64'h1234_5678_9ABC_D000, 128, 0, 32, 4'hF, 4'hF, 8'hFF, 1'b0};
        segs[8]  = '{64'h1234_5678_9ABC_D080, 128, 128, 32, 4'hF, 4'hF, 8'h00, 1'b0};
        segs[9]  = '{64'h1234_5678_9ABC_D100, 128, 256, 32, 4'hF, 4'hF, 8'h01, 1'b1};
        // Write 2 B @0x205: single DW, masked first_be
        segs[10] = '{64'h205, 2, 0, 1, 4'b0110, 4'b0000, 8'h41, 1'b1};

        reqs[0] = '{1'b0, 64'h1000, 256, 8'h10, 0, 2, -1};
        reqs[1] = '{1'b0, 64'h7E, 10, 8'h20, 2, 2, -1};
        reqs[2] = '{1'b1, 64'h1F00, 1024, 8'h30, 4, 3, 1};
        reqs[3] = '{1'b0, 64'h1234_5678_9ABC_D000, 384, 8'hFF, 7, 3, -1};
        reqs[4] = '{1'b0, 64'h205, 2, 8'h41, 10, 1, -1};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 128'(req_ready_o), 128'(1));
        chk("rst_hdr_valid", 128'(hdr_valid_o), 128'(0));
        chk("rst_hdr", hdr_o, 128'(0));
        chk("rst_seg_bytes", 128'(seg_bytes_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_req(reqs[i]);

        err_case(0);
        err_case(4097);

        // Reset while a request is being emitted
        @(negedge clk);
        drive_req(1'b0, 64'h1000, 256, 8'h10);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("pre_rst_valid", 128'(hdr_valid_o), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 128'(hdr_valid_o), 128'(0));
        chk("mid_rst_hdr", hdr_o, 128'(0));
        chk("mid_rst_bytes", 128'(seg_bytes_o), 128'(0));
        chk("mid_rst_offset", 128'(seg_offset_o), 128'(0));
        chk("mid_rst_last", 128'(seg_last_o), 128'(0));
        chk("mid_rst_done", 128'(done_o), 128'(0));
        chk("mid_rst_ready", 128'(req_ready_o), 128'(1));

        run_req(reqs[1]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
